// File: rtl/pattern_table_pkg.sv
// Shared types and helpers for the pattern table sequencer: FSM states,
// mode encoding and the per-element init value taken from the pattern.
package pattern_table_pkg;

  localparam int MAX_PAT_BITS = 64 * 64;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // The pattern repeats across the table, so element idx takes pattern slot idx mod pat_len.
  function automatic logic [63:0] pat_elem(input logic [MAX_PAT_BITS-1:0] pat,
                                           input int pat_len,
                                           input int width,
                                           input int idx);
    logic [MAX_PAT_BITS-1:0] shifted;
    logic [63:0] mask;
    shifted = pat >> ((idx % pat_len) * width);
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return shifted[63:0] & mask;
  endfunction

endpackage

// File: rtl/pattern_table_seq_if.sv
// Stream, write-port and status bundle of the pattern table sequencer.
// The slave modport is the sequencer; master is whoever drives it.
interface pattern_table_seq_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 6
);
  localparam int AW = $clog2(DEPTH);

  logic                   start;
  logic                   mode;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [AW-1:0]          out_idx;
  logic                   busy;
  logic                   done;
  logic [DEPTH*WIDTH-1:0] tbl_flat;
  logic [WIDTH-1:0]       first;

  modport master (
    output start, mode, wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_data, out_idx, busy, done, tbl_flat, first
  );

  modport slave (
    input  start, mode, wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_data, out_idx, busy, done, tbl_flat, first
  );

endinterface

// File: rtl/pattern_table_mem.sv
// Register array holding the table: resets to the repeating init pattern,
// one write port, combinational read port and a flat image of all elements.
module pattern_table_mem
  import pattern_table_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 6,
  parameter int PAT_LEN = 2,
  parameter logic [PAT_LEN*WIDTH-1:0] PAT = {32'd5, 32'd4},
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [AW-1:0]          rd_idx,
  output logic [WIDTH-1:0]       rd_data,
  output logic [DEPTH*WIDTH-1:0] tbl_flat,
  output logic [WIDTH-1:0]       first
);

  localparam logic [MAX_PAT_BITS-1:0] PAT_EXT = MAX_PAT_BITS'(PAT);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] tbl [DEPTH];

  // Addresses past the end exist when DEPTH is not a power of two; drop them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= WIDTH'(pat_elem(PAT_EXT, PAT_LEN, WIDTH, i));
      end
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    tbl_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_flat[i*WIDTH +: WIDTH] = tbl[i];
    end
  end

  assign rd_data = tbl[rd_idx];
  assign first   = tbl[0];

endmodule

// File: rtl/pattern_table_seq.sv
// Streams the table out over a valid/ready port, either once or wrapping
// continuously; the table itself lives in pattern_table_mem.
module pattern_table_seq
  import pattern_table_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 6,
  parameter int PAT_LEN = 2,
  parameter logic [PAT_LEN*WIDTH-1:0] PAT = {32'd5, 32'd4}
) (
  input logic clk,
  input logic rst,
  pattern_table_seq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state;
  logic          mode_q;
  logic          valid_q;
  logic          done_q;
  logic          busy_q;
  logic [AW-1:0] idx_q;
  logic          transfer;

  assign transfer = valid_q && bus.out_ready;

  pattern_table_mem #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PAT_LEN (PAT_LEN),
    .PAT     (PAT),
    .AW      (AW)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_idx   (idx_q),
    .rd_data  (bus.out_data),
    .tbl_flat (bus.tbl_flat),
    .first    (bus.first)
  );

  // A start always wins, even over the final one-shot beat, so done stays low then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= MODE_ONESHOT;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        state   <= RUN;
        mode_q  <= bus.mode;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        idx_q   <= '0;
      end else begin
        case (state)
          IDLE: begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          RUN: begin
            if (transfer) begin
              if (idx_q == LAST_IDX) begin
                if (mode_q == MODE_CONT) begin
                  idx_q <= '0;
                end else begin
                  state   <= DRAIN;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          DRAIN: begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pattern_table_seq.sv
// Self-checking bench for pattern_table_seq: directed scenarios plus random
// traffic, compared every cycle against a behavioural stream/table model.
module tb_pattern_table_seq;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 6;
  localparam int PAT_LEN = 2;
  localparam logic [PAT_LEN*WIDTH-1:0] PAT = {32'd5, 32'd4};
  localparam logic [DEPTH*WIDTH-1:0] PATTERN_FLAT =
    192'h000000050000000400000005000000040000000500000004;

  logic clk;
  logic rst;

  pattern_table_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pattern_table_seq #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PAT_LEN (PAT_LEN),
    .PAT     (PAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  // Behavioural model: table contents plus where the stream currently stands.
  logic [WIDTH-1:0] m_tbl [DEPTH];
  logic m_valid, m_busy, m_done, m_mode, m_ending;
  int   m_idx;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] modelFlat();
    logic [DEPTH*WIDTH-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*WIDTH +: WIDTH] = m_tbl[i];
    return f;
  endfunction

  task automatic updateModel();
    logic xfer;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = PAT[(i % PAT_LEN)*WIDTH +: WIDTH];
      m_valid = 0; m_busy = 0; m_done = 0; m_ending = 0; m_idx = 0; m_mode = 0;
      return;
    end
    xfer = m_valid && bus.out_ready;
    if (bus.wr_en && int'(bus.wr_addr) < DEPTH) m_tbl[bus.wr_addr] = bus.wr_data;
    m_done = 0;
    if (bus.start) begin
      m_valid = 1; m_busy = 1; m_idx = 0; m_mode = bus.mode; m_ending = 0;
    end else if (m_ending) begin
      m_ending = 0; m_busy = 0;
    end else if (xfer) begin
      if (m_idx == DEPTH - 1) begin
        if (m_mode) m_idx = 0;
        else begin
          m_valid = 0; m_done = 1; m_ending = 1;
        end
      end else begin
        m_idx = m_idx + 1;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 256'(bus.out_valid), 256'(m_valid));
    checkOutput("busy", 256'(bus.busy), 256'(m_busy));
    checkOutput("done", 256'(bus.done), 256'(m_done));
    checkOutput("tbl_flat", 256'(bus.tbl_flat), 256'(modelFlat()));
    checkOutput("first", 256'(bus.first), 256'(m_tbl[0]));
    if (m_valid) begin
      checkOutput("out_idx", 256'(bus.out_idx), 256'(m_idx));
      checkOutput("out_data", 256'(bus.out_data), 256'(m_tbl[m_idx]));
    end
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic md,
                               input logic we, input logic [2:0] wa,
                               input logic [31:0] wd, input logic rdy);
    rst = r; bus.start = st; bus.mode = md; bus.wr_en = we;
    bus.wr_addr = wa; bus.wr_data = wd; bus.out_ready = rdy;
    @(posedge clk);
    updateModel();
    #1;
    compareAll();
  endtask

  logic [WIDTH-1:0] beats [$];
  logic [WIDTH-1:0] exp_oneshot [DEPTH];
  logic [WIDTH-1:0] idx3_data;
  logic [DEPTH*WIDTH-1:0] flat_before;
  logic wrap_pending;

  initial begin
    exp_oneshot = '{32'd4, 32'd5, 32'd4, 32'd5, 32'd4, 32'd5};
    rst = 1; bus.start = 0; bus.mode = 0; bus.wr_en = 0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 0;

    // Reset, then idle
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_flat", 256'(bus.tbl_flat), 256'(PATTERN_FLAT));
    checkOutput("reset_first", 256'(bus.first), 256'(32'd4));
    checkOutput("reset_idx", 256'(bus.out_idx), 256'(0));

    // One-shot pass with the consumer always ready
    done_cnt = 0;
    beats.delete();
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) beats.push_back(bus.out_data);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("oneshot_beats", 256'(beats.size()), 256'(DEPTH));
    for (int i = 0; i < DEPTH && i < beats.size(); i++)
      checkOutput("oneshot_data", 256'(beats[i]), 256'(exp_oneshot[i]));
    checkOutput("oneshot_done_cnt", 256'(done_cnt), 256'(1));
    checkOutput("oneshot_busy_end", 256'(bus.busy), 256'(0));

    // Continuous mode with ready toggling
    done_cnt = 0;
    wrap_pending = 0;
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 30; c++) begin
      logic rdy;
      rdy = c[0];
      if (wrap_pending) begin
        checkOutput("wrap_idx", 256'(bus.out_idx), 256'(0));
        checkOutput("wrap_data", 256'(bus.out_data), 256'(32'd4));
        wrap_pending = 0;
      end
      if (bus.out_valid && rdy && bus.out_idx == 3'd5) wrap_pending = 1;
      applyStimulus(0, 0, 1, 0, 0, 0, rdy);
    end
    checkOutput("cont_done_cnt", 256'(done_cnt), 256'(0));
    checkOutput("cont_busy", 256'(bus.busy), 256'(1));

    // Write into the table during a stream
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3'd3, 32'hDEAD_BEEF, 0);
    idx3_data = '0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid && bus.out_idx == 3'd3) idx3_data = bus.out_data;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("wr_beat3", 256'(idx3_data), 256'(32'hDEAD_BEEF));
    checkOutput("wr_flat3", 256'(bus.tbl_flat[127:96]), 256'(32'hDEAD_BEEF));
    checkOutput("wr_first", 256'(bus.first), 256'(32'd4));

    // Out-of-range write leaves the table alone
    flat_before = modelFlat();
    applyStimulus(0, 0, 0, 1, 3'd7, 32'h1234_5678, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wr_oob", 256'(bus.tbl_flat), 256'(flat_before));

    // Reset in the middle of a stream
    done_cnt = 0;
    applyStimulus(0, 1, 0, 1, 3'd1, 32'hCAFE_F00D, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("mid_idx", 256'(bus.out_idx), 256'(2));
    applyStimulus(1, 1, 0, 1, 3'd2, 32'h0BAD_0BAD, 1);
    checkOutput("mid_rst_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("mid_rst_flat", 256'(bus.tbl_flat), 256'(PATTERN_FLAT));
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("mid_rst_done_cnt", 256'(done_cnt), 256'(0));

    // Start coinciding with the final one-shot beat
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    for (int c = 0; c < DEPTH - 1; c++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("restart_done", 256'(bus.done), 256'(0));
    checkOutput("restart_idx", 256'(bus.out_idx), 256'(0));

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      applyStimulus(($urandom_range(63) == 0),
                    ($urandom_range(15) == 0),
                    1'($urandom_range(1)),
                    ($urandom_range(7) == 0),
                    3'($urandom_range(7)),
                    $urandom,
                    ($urandom_range(9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
